// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encodings and baud/oversample constants
// used by both the receiver and the existing transmitter.
package uart_pkg;

    localparam int OVERSAMPLE_DEFAULT = 16;
    localparam int BAUD_DIV_115200    = 27;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input pin; the reset value
// is a parameter so idle-high lines do not look like an edge after reset.
module sync_2ff #(
    parameter bit RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments so both flops sample on the same edge and
    // the chain stays two stages deep regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, ready/clear handshake and sticky
// framing/overrun flags. Define UART_RX_PARITY_EN to add a parity bit check.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk_50m,
    input  logic                 clr,
    input  logic                 rxclk_en,
    input  logic                 Rx,
    input  logic                 ready_clr,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 ready,
    output logic                 Rx_busy,
    output logic                 Frame_err,
    output logic                 Overrun
`ifdef UART_RX_PARITY_EN
    ,
    output logic                 Parity_err
`endif
);

    localparam int SAMPLE_W = $clog2(OVERSAMPLE);
    localparam int BIT_W    = $clog2(DATA_BITS + 1);

    localparam logic [SAMPLE_W-1:0] SAMPLE_MID  = SAMPLE_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SAMPLE_W-1:0] SAMPLE_LAST = SAMPLE_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]    BIT_LAST    = BIT_W'(DATA_BITS - 1);

    logic rx_s;

    rx_state_e             state_q,  state_d;
    logic [SAMPLE_W-1:0]   sample_q, sample_d;
    logic [BIT_W-1:0]      bit_q,    bit_d;
    logic [DATA_BITS-1:0]  shift_q,  shift_d;
    logic [DATA_BITS-1:0]  data_q,   data_d;
    logic                  ready_q,  ready_d;
    logic                  ferr_q,   ferr_d;
    logic                  ovr_q,    ovr_d;
    logic                  busy_q,   busy_d;
`ifdef UART_RX_PARITY_EN
    logic                  perr_q,   perr_d;
`endif

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk    (clk_50m),
        .rst_n  (clr),
        .async_i(Rx),
        .sync_o (rx_s)
    );

    always_ff @(posedge clk_50m or negedge clr) begin
        if (!clr) begin
            state_q  <= IDLE;
            sample_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            ready_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
            busy_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            ready_q  <= ready_d;
            ferr_q   <= ferr_d;
            ovr_q    <= ovr_d;
            busy_q   <= busy_d;
`ifdef UART_RX_PARITY_EN
            perr_q   <= perr_d;
`endif
        end
    end

    // NOTE: every _d variable takes its hold value first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        data_d   = data_q;
        ready_d  = ready_q;
        ferr_d   = ferr_q;
        ovr_d    = ovr_q;
`ifdef UART_RX_PARITY_EN
        perr_d   = perr_q;
`endif

        // The clear is applied first so a coinciding completion overrides it.
        if (ready_clr) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            ovr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_d  = 1'b0;
`endif
        end

        if (rxclk_en) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_d  = START;
                        sample_d = '0;
                    end
                end
                START: begin
                    if (sample_q == SAMPLE_MID) begin
                        if (!rx_s) begin
                            state_d  = DATA;
                            sample_d = '0;
                            bit_d    = '0;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        sample_d = sample_q + 1'b1;
                    end
                end
                DATA: begin
                    sample_d = sample_q + 1'b1;
                    if (sample_q == SAMPLE_LAST) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    sample_d = sample_q + 1'b1;
                    if (sample_q == SAMPLE_LAST) begin
                        if ((^shift_q ^ rx_s) != PARITY_ODD) begin
                            perr_d = 1'b1;
                        end
                        state_d = STOP;
                    end
                end
`endif
                STOP: begin
                    sample_d = sample_q + 1'b1;
                    if (sample_q == SAMPLE_LAST) begin
                        data_d  = shift_q;
                        state_d = IDLE;
                        if (rx_s) begin
                            ready_d = 1'b1;
                            if (ready_q && !ready_clr) begin
                                ovr_d = 1'b1;
                            end
                        end else begin
                            ferr_d = 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    assign data_out  = data_q;
    assign ready     = ready_q;
    assign Rx_busy   = busy_q;
    assign Frame_err = ferr_q;
    assign Overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
    assign Parity_err = perr_q;
`endif

endmodule
